write_back_stage: RTL

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

---
 rtl/write_back_stage_if.sv | 50 +++++
 rtl/write_back_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/write_back_stage_if.sv
// MEM/WB-side bundle for the write-back stage: pipeline inputs, register-file
// write and bypass outputs, counter read port and fault status.
interface write_back_stage_if;
  logic        MEM_WB_valid;
  logic [4:0]  MEM_WB_RD;
  logic        MEM_WB_regwrite_en;
  logic        MEM_WB_wb_sel;
  logic [31:0] MEM_WB_ALU_OUT;
  logic [31:0] MEM_WB_LOAD_ALU_OUT;
  logic [2:0]  MEM_WB_funct3;

  logic        WB_ID_regwrite;
  logic [31:0] WB_ID_WD;
  logic [4:0]  WB_ID_RDW_addr;

  logic        WB_BYP_valid;
  logic [31:0] WB_BYP_WD;
  logic [4:0]  WB_BYP_RD;

  logic        ctr_rd;
  logic [1:0]  ctr_sel;
  logic [31:0] ctr_rdata;
  logic        ctr_rvalid;

  // Debug preload of a counter (sel 0 = cycle, 1 = instret), used to reach wrap points quickly
  logic        ctr_load;
  logic        ctr_load_sel;
  logic [63:0] ctr_load_data;

  logic        load_fault;
  logic        fault_clr;

  modport master (
    output MEM_WB_valid, MEM_WB_RD, MEM_WB_regwrite_en, MEM_WB_wb_sel,
           MEM_WB_ALU_OUT, MEM_WB_LOAD_ALU_OUT, MEM_WB_funct3,
           ctr_rd, ctr_sel, ctr_load, ctr_load_sel, ctr_load_data, fault_clr,
    input  WB_ID_regwrite, WB_ID_WD, WB_ID_RDW_addr,
           WB_BYP_valid, WB_BYP_WD, WB_BYP_RD,
           ctr_rdata, ctr_rvalid, load_fault
  );

  modport slave (
    input  MEM_WB_valid, MEM_WB_RD, MEM_WB_regwrite_en, MEM_WB_wb_sel,
           MEM_WB_ALU_OUT, MEM_WB_LOAD_ALU_OUT, MEM_WB_funct3,
           ctr_rd, ctr_sel, ctr_load, ctr_load_sel, ctr_load_data, fault_clr,
    output WB_ID_regwrite, WB_ID_WD, WB_ID_RDW_addr,
           WB_BYP_valid, WB_BYP_WD, WB_BYP_RD,
           ctr_rdata, ctr_rvalid, load_fault
  );
endinterface

// File: rtl/write_back_stage.sv
// Write-back stage: load extraction and alignment checking, register-file write,
// one-cycle-late bypass, cycle/instret counters with hi-word snapshots, sticky fault.
module write_back_stage (
  input  logic              clk,
  input  logic              rst,
  write_back_stage_if.slave wb
);

  logic [1:0]  off;
  logic [31:0] word;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;
  logic [31:0] selData;
  logic        loadFault;
  logic        fault;
  logic        commit;
  logic        retire;
  logic [31:0] wdOut;
  logic [4:0]  rdOut;

  logic        bypValid_q, bypValid_d;
  logic [31:0] bypWd_q, bypWd_d;
  logic [4:0]  bypRd_q, bypRd_d;
  logic [63:0] cycleCount_q, cycleCount_d;
  logic [63:0] instretCount_q, instretCount_d;
  logic [31:0] cycleSnap_q, cycleSnap_d;
  logic [31:0] instretSnap_q, instretSnap_d;
  logic [31:0] ctrRdata_q, ctrRdata_d;
  logic        ctrRvalid_q, ctrRvalid_d;
  logic        faultFlag_q, faultFlag_d;

  // Load extraction from the aligned memory word and misalignment/illegal-width detection
  always_comb begin
    off      = wb.MEM_WB_ALU_OUT[1:0];
    word     = wb.MEM_WB_LOAD_ALU_OUT;
    byteSel  = 8'h00;
    unique case (off)
      2'd0:    byteSel = word[7:0];
      2'd1:    byteSel = word[15:8];
      2'd2:    byteSel = word[23:16];
      default: byteSel = word[31:24];
    endcase
    halfSel  = off[1] ? word[31:16] : word[15:0];
    loadData  = 32'h0;
    loadFault = 1'b0;
    unique case (wb.MEM_WB_funct3)
      3'b000: loadData = {{24{byteSel[7]}}, byteSel};
      3'b100: loadData = {24'h0, byteSel};
      3'b001: begin
        loadData  = {{16{halfSel[15]}}, halfSel};
        loadFault = off[0];
      end
      3'b101: begin
        loadData  = {16'h0, halfSel};
        loadFault = off[0];
      end
      3'b010: begin
        loadData  = word;
        loadFault = (off != 2'b00);
      end
      default: loadFault = 1'b1;
    endcase
    loadFault = loadFault & wb.MEM_WB_wb_sel;
    selData   = wb.MEM_WB_wb_sel ? loadData : wb.MEM_WB_ALU_OUT;
  end

  always_comb begin
    fault  = wb.MEM_WB_valid & loadFault;
    retire = wb.MEM_WB_valid & ~loadFault;
    commit = ~rst & retire & wb.MEM_WB_regwrite_en & (wb.MEM_WB_RD != 5'd0);
    wdOut  = commit ? selData : 32'h0;
    rdOut  = commit ? wb.MEM_WB_RD : 5'd0;
  end

  assign wb.WB_ID_regwrite = commit;
  assign wb.WB_ID_WD       = wdOut;
  assign wb.WB_ID_RDW_addr = rdOut;

  // Next-state for bypass, counters, snapshots and the sticky fault flag
  always_comb begin
    bypValid_d = commit;
    bypWd_d    = wdOut;
    bypRd_d    = rdOut;

    cycleCount_d = cycleCount_q + 64'd1;
    if (wb.ctr_load && !wb.ctr_load_sel) cycleCount_d = wb.ctr_load_data;

    instretCount_d = retire ? instretCount_q + 64'd1 : instretCount_q;
    if (wb.ctr_load && wb.ctr_load_sel) instretCount_d = wb.ctr_load_data;

    cycleSnap_d   = cycleSnap_q;
    instretSnap_d = instretSnap_q;
    ctrRdata_d    = ctrRdata_q;
    ctrRvalid_d   = wb.ctr_rd;
    if (wb.ctr_rd) begin
      unique case (wb.ctr_sel)
        2'b00: begin
          ctrRdata_d  = cycleCount_q[31:0];
          cycleSnap_d = cycleCount_q[63:32];
        end
        2'b01: ctrRdata_d = cycleSnap_q;
        2'b10: begin
          ctrRdata_d    = instretCount_q[31:0];
          instretSnap_d = instretCount_q[63:32];
        end
        default: ctrRdata_d = instretSnap_q;
      endcase
    end

    // A new fault takes priority over a simultaneous clear
    faultFlag_d = faultFlag_q;
    if (fault)             faultFlag_d = 1'b1;
    else if (wb.fault_clr) faultFlag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bypValid_q     <= 1'b0;
      bypWd_q        <= 32'h0;
      bypRd_q        <= 5'd0;
      cycleCount_q   <= 64'd0;
      instretCount_q <= 64'd0;
      cycleSnap_q    <= 32'h0;
      instretSnap_q  <= 32'h0;
      ctrRdata_q     <= 32'h0;
      ctrRvalid_q    <= 1'b0;
      faultFlag_q    <= 1'b0;
    end else begin
      bypValid_q     <= bypValid_d;
      bypWd_q        <= bypWd_d;
      bypRd_q        <= bypRd_d;
      cycleCount_q   <= cycleCount_d;
      instretCount_q <= instretCount_d;
      cycleSnap_q    <= cycleSnap_d;
      instretSnap_q  <= instretSnap_d;
      ctrRdata_q     <= ctrRdata_d;
      ctrRvalid_q    <= ctrRvalid_d;
      faultFlag_q    <= faultFlag_d;
    end
  end

  assign wb.WB_BYP_valid = bypValid_q;
  assign wb.WB_BYP_WD    = bypWd_q;
  assign wb.WB_BYP_RD    = bypRd_q;
  assign wb.ctr_rdata    = ctrRdata_q;
  assign wb.ctr_rvalid   = ctrRvalid_q;
  assign wb.load_fault   = faultFlag_q;

endmodule
